// File: rtl/lab2_frame_tx_if.sv
`default_nettype none
// ==================================================================
// lab2_frame_tx_if : word handshake and serial output bundle
// Rev 1.0
// ==================================================================
interface lab2_frame_tx_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              serial_out;
  logic              busy;
  logic              done;
  logic [2:0]        S;

  modport master (
    output data_in, valid,
    input  ready, serial_out, busy, done, S
  );

  modport slave (
    input  data_in, valid,
    output ready, serial_out, busy, done, S
  );
endinterface
`default_nettype wire

// File: rtl/lab2_frame_tx.sv
`default_nettype none
// ==================================================================
// lab2_frame_tx : sends sync marker, MSB-first payload, guard zeros
// Rev 1.0
// ==================================================================
module lab2_frame_tx #(
  parameter int                SYNC_W  = 4,
  parameter logic [SYNC_W-1:0] SYNC    = 4'b1001,
  parameter int                DATA_W  = 8,
  parameter int                GAP_LEN = 2
) (
  input  logic           clock,
  input  logic           reset,
  lab2_frame_tx_if.slave bus
);

  localparam int c_FR_W  = SYNC_W + DATA_W;
  localparam int c_MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int c_MAX_N = (c_MAX_A > GAP_LEN) ? c_MAX_A : GAP_LEN;
  localparam int c_CNT_W = (c_MAX_N > 1) ? $clog2(c_MAX_N) : 1;

  localparam logic [c_CNT_W-1:0] c_SYNC_LD = c_CNT_W'(SYNC_W - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_LD = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LD  = c_CNT_W'(GAP_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_GAP  = 3'd3
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_FR_W-1:0]   r_frame;
  logic                r_serial;
  logic                r_done;
  logic [c_FR_W-1:0]   w_shift;

  // Sync marker and payload share one shift register, so the MSB is always the next bit.
  assign w_shift = r_frame << 1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_frame  <= '0;
      r_serial <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_serial <= 1'b0;
          if (bus.valid) begin
            r_frame  <= {SYNC, bus.data_in};
            r_cnt    <= c_SYNC_LD;
            r_state  <= ST_SYNC;
            r_serial <= SYNC[SYNC_W-1];
          end
        end
        ST_SYNC: begin
          r_frame  <= w_shift;
          r_serial <= w_shift[c_FR_W-1];
          if (r_cnt == '0) begin
            r_cnt   <= c_DATA_LD;
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt - c_ONE;
          end
        end
        ST_DATA: begin
          if (r_cnt == '0) begin
            r_serial <= 1'b0;
            r_cnt    <= c_GAP_LD;
            r_state  <= ST_GAP;
            r_done   <= (GAP_LEN == 1);
          end else begin
            r_frame  <= w_shift;
            r_serial <= w_shift[c_FR_W-1];
            r_cnt    <= r_cnt - c_ONE;
          end
        end
        ST_GAP: begin
          r_serial <= 1'b0;
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt  <= r_cnt - c_ONE;
            r_done <= (r_cnt == c_ONE);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_serial <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready      = (r_state == ST_IDLE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = r_done;
  assign bus.serial_out = r_serial;
  assign bus.S          = r_state;

endmodule
`default_nettype wire
